// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the countdown 7-segment display stage.
// No logic of its own; latency n/a.
// No flow control; consumed by seg7_countdown_driver and bin2bcd_seq.
package seg7_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } bcd_state_t;

    // Which digit currently owns the multiplexed display
    typedef enum logic {
        SEL_UNITS = 1'b0,
        SEL_TENS  = 1'b1
    } digit_sel_t;

    // Active-low drive constants
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_UNITS  = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;

    // Largest value the two digits can show; inputs above this saturate
    localparam logic [6:0] MAX_DISP  = 7'd99;

    // Binary input width and the matching double-dabble iteration count
    localparam int         BIN_W     = 7;
    localparam int         BCD_W     = 8;
    localparam int         SHIFT_W   = BIN_W + BCD_W;
    localparam logic [2:0] ITER_LAST = 3'd6;

    // BCD digit to active-low segments, bit order g..a
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would carry past 9 after
    // the next doubling, so pre-add 3 to land the carry in the next nibble
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 7-bit binary to 2-digit BCD converter (shift-and-add-3).
// Latency: start edge + 7 shift edges + 1 done edge; done pulses 1 cycle after DONE.
// No backpressure: start is only accepted while idle (busy=0); rst=0 aborts with no result.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    bcd_state_t          r_state;
    bcd_state_t          w_state_nxt;
    logic                w_load;
    logic                w_step;
    logic                w_commit;

    // {tens nibble, units nibble, remaining binary bits}
    logic [SHIFT_W-1:0]  r_shift;
    logic [SHIFT_W-1:0]  w_adj;
    logic [SHIFT_W-1:0]  w_shifted;
    logic [2:0]          r_iter;

    logic                r_done;
    logic [3:0]          r_tens;
    logic [3:0]          r_units;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state datapath controls
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_step = 1'b1;
                if (r_iter == ITER_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One double-dabble iteration: correct both BCD nibbles, then shift left
    always_comb begin
        w_adj     = {dd_adjust(r_shift[SHIFT_W-1 -: 4]),
                     dd_adjust(r_shift[SHIFT_W-5 -: 4]),
                     r_shift[BIN_W-1:0]};
        w_shifted = w_adj << 1;
    end

    // Shift register and iteration counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shift <= '0;
            r_iter  <= '0;
        end else if (w_load) begin
            r_shift <= {{BCD_W{1'b0}}, bin};
            r_iter  <= '0;
        end else if (w_step) begin
            r_shift <= w_shifted;
            r_iter  <= r_iter + 3'd1;
        end
    end

    // Result registers; done is a single-cycle strobe following DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done  <= 1'b0;
            r_tens  <= '0;
            r_units <= '0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_tens  <= r_shift[SHIFT_W-1 -: 4];
                r_units <= r_shift[SHIFT_W-5 -: 4];
            end
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign tens  = r_tens;
    assign units = r_units;

endmodule

// File: rtl/seg7_countdown_driver.sv
// Countdown seconds -> saturated 2-digit BCD -> multiplexed common-anode 7-seg drive.
// Latency: display digits update 9 edges after capture; anode/cathode are 1 cycle behind.
// No backpressure: input changes while busy are dropped, newest value is recompared when idle.
// Build option LEADING_ZERO_BLANK_EN: blank the tens digit when it is zero.
module seg7_countdown_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] time_left,
    output logic             busy,
    output logic [1:0]       anode,
    output logic [7:0]       cathode
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [BIN_W-1:0] w_sat;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [3:0]       w_tens;
    logic [3:0]       w_units;

    logic [BIN_W-1:0] r_last_val;
    logic [3:0]       r_disp_tens;
    logic [3:0]       r_disp_units;
    logic [CNT_W-1:0] r_cnt;
    digit_sel_t       r_digit_sel;
    logic [1:0]       r_anode;
    logic [7:0]       r_cathode;
    logic [1:0]       w_anode_nxt;
    logic [7:0]       w_cathode_nxt;

    // Two digits cannot show more than 99
    assign w_sat   = (time_left > MAX_DISP) ? MAX_DISP : time_left;

    // Only convert when idle and the value actually moved
    assign w_start = !w_busy && (w_sat != r_last_val);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (w_sat),
        .busy  (w_busy),
        .done  (w_done),
        .tens  (w_tens),
        .units (w_units)
    );

    // Remember the value handed to the converter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_val <= '0;
        end else if (w_start) begin
            r_last_val <= w_sat;
        end
    end

    // Commit a finished conversion to the display digits
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_disp_tens  <= '0;
            r_disp_units <= '0;
        end else if (w_done) begin
            r_disp_tens  <= w_tens;
            r_disp_units <= w_units;
        end
    end

    // Slot timer: each digit owns the display for REFRESH_DIV cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_digit_sel <= SEL_UNITS;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_digit_sel <= (r_digit_sel == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
        end else begin
            r_cnt       <= r_cnt + 1'b1;
        end
    end

    // Pick anode and segments for the current slot; DP is always off
    always_comb begin
        w_anode_nxt   = AN_UNITS;
        w_cathode_nxt = {1'b1, seg_decode(r_disp_units)};
        if (r_digit_sel == SEL_TENS) begin
            w_anode_nxt   = AN_TENS;
`ifdef LEADING_ZERO_BLANK_EN
            if (r_disp_tens == 4'd0) begin
                w_cathode_nxt = SEG_BLANK;
            end else begin
                w_cathode_nxt = {1'b1, seg_decode(r_disp_tens)};
            end
`else
            w_cathode_nxt = {1'b1, seg_decode(r_disp_tens)};
`endif
        end
    end

    // Registered pad drive; everything dark while in reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_anode   <= AN_OFF;
            r_cathode <= SEG_BLANK;
        end else begin
            r_anode   <= w_anode_nxt;
            r_cathode <= w_cathode_nxt;
        end
    end

    assign busy    = w_busy;
    assign anode   = r_anode;
    assign cathode = r_cathode;

endmodule

// File: tb/tb_seg7_countdown_driver.sv
// Scoreboard bench for seg7_countdown_driver with a fast refresh divider.
// A reference model pushes the value each accepted conversion should display;
// a monitor pops on every completed conversion and checks the multiplexed output.
module tb_seg7_countdown_driver;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] time_left = 7'd0;
    logic       busy;
    logic [1:0] anode;
    logic [7:0] cathode;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int n_conv = 0;
    int n_expected = 0;

    seg7_countdown_driver #(.REFRESH_DIV(RDIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .time_left (time_left),
        .busy      (busy),
        .anode     (anode),
        .cathode   (cathode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Segment patterns gfedcba, active low
    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] exp_cathode(input int value, input bit tens_slot);
        int d;
        d = tens_slot ? (value / 10) : (value % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (tens_slot && d == 0) return 8'hFF;
`endif
        return {1'b1, seg_ref(d)};
    endfunction

    // Compare one sample of the display against a decimal value
    task automatic check_slot(input string tag, input int value);
        if (anode == 2'b10) begin
            chk({tag, "_units"}, cathode, exp_cathode(value, 1'b0));
        end else if (anode == 2'b01) begin
            chk({tag, "_tens"}, cathode, exp_cathode(value, 1'b1));
        end else begin
            chk({tag, "_anode_onehot"}, anode, 2'b10);
        end
    endtask

    // Reference model: a new saturated value is accepted when it differs from the
    // last accepted one and at least 9 cycles have passed since the previous accept;
    // reset drops any conversion still in flight and forgets the last value.
    int m_cyc = 0;
    int m_free_at = 0;
    int m_last = 0;
    always @(posedge clk) begin
        int s;
        int dropped;
        m_cyc++;
        if (!rst) begin
            if (m_cyc < m_free_at && exp_q.size() > 0) begin
                dropped = exp_q.pop_back();
                n_expected--;
            end
            m_free_at = 0;
            m_last = 0;
        end else if (m_cyc >= m_free_at) begin
            s = (int'(time_left) > 99) ? 99 : int'(time_left);
            if (s != m_last) begin
                exp_q.push_back(s);
                n_expected++;
                m_last = s;
                m_free_at = m_cyc + 9;
            end
        end
    end

    // Monitor: each busy falling edge is a completed conversion; check its busy
    // width, then check the display for 7 samples once the new digits reach the pins
    int  mon_age = 99;
    int  mon_val = 0;
    int  bcnt = 0;
    bit  prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
            mon_age = 99;
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (prev_busy && !busy) begin
                n_conv++;
                chk("busy_width", bcnt, 8);
                bcnt = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL conv_expected: conversion finished but none expected (t=%0t)", $time);
                    mon_age = 99;
                end else begin
                    mon_val = exp_q.pop_front();
                    mon_age = 0;
                end
            end else if (mon_age < 9) begin
                mon_age++;
                if (mon_age >= 2 && mon_age <= 8) check_slot("disp", mon_val);
            end
            prev_busy = busy;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int conv0;
        int busy_hi;
        bit seen;
        int v;

        // 1. reset state, then idle display of 00 with 4-cycle slots
        rst = 1'b0;
        time_left = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", anode, 2'b11);
        chk("rst_cathode", cathode, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("idle_anode", anode, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
            check_slot("idle", 0);
            chk("idle_busy", busy, 1'b0);
        end

        // 2. simple conversion
        time_left = 7'd15;
        wait_neg(20);

        // 3. saturation, and no reconversion of the same saturated value
        time_left = 7'd120;
        wait_neg(20);
        conv0 = n_conv;
        time_left = 7'd99;
        busy_hi = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy) busy_hi++;
        end
        chk("sat_no_reconv_busy", busy_hi, 0);

        // 4. change mid-conversion: both values convert in order
        conv0 = n_conv;
        time_left = 7'd37;
        wait_neg(3);
        time_left = 7'd42;
        wait_neg(30);
        chk("midconv_count", n_conv - conv0, 2);

        // 5. reset on the 4th shift cycle aborts, then reconverts
        time_left = 7'd88;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("abort_busy_seen", seen, 1'b1);
        wait_neg(3);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_anode", anode, 2'b11);
        chk("abort_cathode", cathode, 8'hFF);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_anode", anode, 2'b10);
        chk("post_abort_cathode", cathode, exp_cathode(0, 1'b0));
        chk("post_abort_restart", busy, 1'b1);
        wait_neg(20);

        // 6. single digit value (tens blank or drawn as 0 depending on build)
        time_left = 7'd7;
        wait_neg(20);

        // random phase: random values held for random times
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                v = $urandom_range(0, 127);
                time_left = 7'(v);
            end
            wait_neg($urandom_range(1, 14));
        end

        wait_neg(30);
        chk("queue_drained", exp_q.size(), 0);
        chk("conv_count", n_conv, n_expected);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
